fsm_rr_scheduler: RTL and testbench



---
 rtl/fsm_rr_scheduler_if.sv | 25 ++
 rtl/fsm_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_fsm_rr_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fsm_rr_scheduler_if.sv
// Handshake bundle between the requesters and the round-robin sequencer scheduler.
// The master side is the requester population; the slave side is the scheduler.
interface fsm_rr_scheduler_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) ();
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_x1;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             res_start;
   logic             res_x1;
   logic             busy;
   logic [N_REQ-1:0] done;

   modport master (
      output req, req_x1,
      input  gnt, gnt_idx, res_start, res_x1, busy, done
   );

   modport slave (
      input  req, req_x1,
      output gnt, gnt_idx, res_start, res_x1, busy, done
   );
endinterface

// File: rtl/fsm_rr_scheduler.sv
// Shares one sequencer among N_REQ requesters: round-robin grant, fixed-length run, done pulse.
// Define FSM_SCHED_FIXED_PRIO_EN to pin the pointer at 0 (fixed priority, index 0 highest).
module fsm_rr_scheduler #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned TXN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   fsm_rr_scheduler_if.slave bus
);

   localparam int unsigned CNT_W = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;

   typedef logic [N_REQ-1:0] req_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             res_start_q, res_start_d;
   logic             res_x1_q, res_x1_d;
   logic             busy_q, busy_d;
   req_t             done_q, done_d;

   logic             found;
   logic [IDX_W-1:0] win_idx;
   req_t             win_oh;
   int unsigned      cand;

   // First set request scanning ptr, ptr+1, ... with wrap at N_REQ
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!found && (|(bus.req & (req_t'(1) << cand)))) begin
            found   = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
      win_oh = req_t'(1) << win_idx;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      res_start_d = 1'b0;
      res_x1_d    = res_x1_q;
      busy_d      = busy_q;
      done_d      = '0;

      case (state_q)
         S_IDLE: begin
            gnt_d    = '0;
            busy_d   = 1'b0;
            res_x1_d = 1'b0;
            if (found) begin
               gnt_d       = win_oh;
               gnt_idx_d   = win_idx;
               res_x1_d    = |(bus.req_x1 & win_oh);
               res_start_d = 1'b1;
               busy_d      = 1'b1;
               cnt_d       = CNT_W'(TXN_CYCLES - 1);
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               done_d   = gnt_q;
               gnt_d    = '0;
               busy_d   = 1'b0;
               res_x1_d = 1'b0;
               ptr_d    = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef FSM_SCHED_FIXED_PRIO_EN
      ptr_d = '0;
`else
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         res_start_q <= 1'b0;
         res_x1_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         res_start_q <= res_start_d;
         res_x1_q    <= res_x1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.res_start = res_start_q;
   assign bus.res_x1    = res_x1_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_fsm_rr_scheduler.sv
// Scoreboard bench for fsm_rr_scheduler: expected grants queued at drive time, checked on start/done.
module tb_fsm_rr_scheduler;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned TXN   = 3;
   localparam int          PER   = TXN + 2;

   typedef struct {
      int   idx;
      logic x1;
      int   start;
   } txn_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_errors;
   txn_t exp_q[$];

   logic       active;
   logic [3:0] cur_oh;
   logic       cur_x1;
   int         cur_start;

   fsm_rr_scheduler_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus_if ();

   fsm_rr_scheduler #(.N_REQ(N_REQ), .IDX_W(IDX_W), .TXN_CYCLES(TXN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_txn(input int idx, input logic x1, input int start);
      txn_t t;
      t.idx   = idx;
      t.x1    = x1;
      t.start = start;
      exp_q.push_back(t);
   endtask

   // Monitor: pops an expectation on every start strobe, checks hold and done timing
   always @(negedge clk) begin
      if (reset) begin
         active = 1'b0;
      end else begin
         check_eq("gnt_onehot0", 32'($onehot0(bus_if.gnt)), 32'd1);
         check_eq("done_gnt_overlap", 32'((|bus_if.done) && (|bus_if.gnt)), 32'd0);
         if (bus_if.res_start) begin
            check_eq("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               txn_t e;
               e = exp_q.pop_front();
               cur_oh    = 4'd1 << e.idx;
               cur_x1    = e.x1;
               cur_start = cyc;
               active    = 1'b1;
               check_eq("gnt", 32'(bus_if.gnt), 32'(cur_oh));
               check_eq("gnt_idx", 32'(bus_if.gnt_idx), 32'(e.idx));
               check_eq("res_x1", 32'(bus_if.res_x1), 32'(e.x1));
               check_eq("busy", 32'(bus_if.busy), 32'd1);
               check_eq("start_cycle", 32'(cyc), 32'(e.start));
            end
         end else if (active && bus_if.done == 4'd0) begin
            check_eq("gnt_hold", 32'(bus_if.gnt), 32'(cur_oh));
            check_eq("res_x1_hold", 32'(bus_if.res_x1), 32'(cur_x1));
            check_eq("busy_hold", 32'(bus_if.busy), 32'd1);
         end
         if (bus_if.done != 4'd0) begin
            check_eq("done_expected", 32'(active), 32'd1);
            check_eq("done", 32'(bus_if.done), 32'(cur_oh));
            check_eq("done_cycle", 32'(cyc), 32'(cur_start + int'(TXN)));
            check_eq("done_busy", 32'(bus_if.busy), 32'd0);
            check_eq("done_res_x1", 32'(bus_if.res_x1), 32'd0);
            active = 1'b0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gnt"}, 32'(bus_if.gnt), 32'd0);
      check_eq({tag, "_res_start"}, 32'(bus_if.res_start), 32'd0);
      check_eq({tag, "_res_x1"}, 32'(bus_if.res_x1), 32'd0);
      check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
      check_eq({tag, "_done"}, 32'(bus_if.done), 32'd0);
   endtask

   initial begin
      int w_skip[3];
      int w_rr[5];
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      active   = 1'b0;
      cur_oh   = '0;
      cur_x1   = 1'b0;
      cur_start = 0;
`ifdef FSM_SCHED_FIXED_PRIO_EN
      w_skip = '{0, 0, 0};
      w_rr   = '{0, 0, 0, 0, 0};
`else
      w_skip = '{0, 2, 0};
      w_rr   = '{0, 1, 2, 3, 0};
`endif
      reset         = 1'b1;
      bus_if.req    = '0;
      bus_if.req_x1 = '0;

      // Reset values, both during and after reset
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      check_eq("rst_gnt_idx", 32'(bus_if.gnt_idx), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("idle");
      check_eq("idle_gnt_idx", 32'(bus_if.gnt_idx), 32'd0);

      // Single request from requester 2
      bus_if.req    = 4'b0100;
      bus_if.req_x1 = 4'b0100;
      push_txn(2, 1'b1, cyc + 1);
      @(negedge clk);
      bus_if.req = '0;
      repeat (TXN + 3) @(negedge clk);
      check_all_zero("after_single");
      check_eq("after_single_gnt_idx", 32'(bus_if.gnt_idx), 32'd2);

      // Pointer at 3, requests 0 and 2: wrap to 0, then 2, then 0
      bus_if.req    = 4'b0101;
      bus_if.req_x1 = 4'b0001;
      for (int k = 0; k < 3; k++)
         push_txn(w_skip[k], (w_skip[k] == 0), cyc + 1 + PER * k);
      repeat (PER * 2 + 1) @(negedge clk);
      bus_if.req = '0;
      repeat (TXN + 3) @(negedge clk);

      // Non-preemption: winner drops req and flips x1 right after the grant
      bus_if.req    = 4'b0010;
      bus_if.req_x1 = 4'b0010;
      push_txn(1, 1'b1, cyc + 1);
      @(negedge clk);
      bus_if.req    = '0;
      bus_if.req_x1 = '0;
      repeat (TXN + 3) @(negedge clk);

      // Reset in the middle of a transaction
      bus_if.req    = 4'b0010;
      bus_if.req_x1 = 4'b0010;
      push_txn(1, 1'b1, cyc + 1);
      repeat (2) @(negedge clk);
      check_eq("pre_rst_gnt", 32'(bus_if.gnt), 32'b0010);
      bus_if.req = '0;
      reset = 1'b1;
      #1;
      check_all_zero("mid_rst");
      check_eq("mid_rst_gnt_idx", 32'(bus_if.gnt_idx), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (TXN + 1) @(negedge clk);
      check_eq("no_done_after_rst", 32'(bus_if.done), 32'd0);

      // Round-robin with everyone requesting, pointer restarted at 0
      bus_if.req    = 4'b1111;
      bus_if.req_x1 = 4'b1010;
      for (int k = 0; k < 5; k++)
         push_txn(w_rr[k], (w_rr[k] == 1 || w_rr[k] == 3), cyc + 1 + PER * k);
      repeat (PER * 4 + 1) @(negedge clk);
      bus_if.req = '0;
      repeat (TXN + 3) @(negedge clk);

      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      check_eq("final_busy", 32'(bus_if.busy), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
